encap_packet_stream: RTL and testbench
======================================

Name: encap_packet_stream

Overview:
- Parametrised successor to the port-0 DFX packet encapsulator.
- Captures one wide DFX word (data + address) plus a per-packet header on arbiter grant, then emits NUM_FLITS Aurora-width flits, each {payload slice, header}.
- Adds output backpressure, a last-flit marker, zero padding of a partial final flit, and mid-packet abort.
- Sits between the input-port arbiter and the Aurora TX interface.

Parameters:
- DATA_DFX_WIDTH, 1034, width of the captured DFX word (DATA_WIDTH + ADDR_WIDTH).
- HEADER_WIDTH, 9, per-packet header width (router id + packet id + TTL).
- AURORA_DATA_WIDTH, 64, flit width.
- PAYLOAD_WIDTH, AURORA_DATA_WIDTH-HEADER_WIDTH (55), payload bits per flit.
- NUM_FLITS, ceil(DATA_DFX_WIDTH/PAYLOAD_WIDTH) (19), flits per packet; derived, not overridden.
- IDX_WIDTH, $clog2(NUM_FLITS) (5), flit counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- data_dfx_send  in  DATA_DFX_WIDTH  DFX word, sampled on grant
- header_pkt_send  in  HEADER_WIDTH  header, sampled on grant
- arbiter_gnt  in  1  start request; accepted only when ready_encap_dfx=1
- encap_abort  in  1  drop the packet in flight
- tx_ready  in  1  downstream accepts the flit this cycle
- data_in_port_0  out  AURORA_DATA_WIDTH  flit {payload, header}, header in LSBs
- data_encap_valid  out  1  flit valid
- data_encap_last  out  1  final flit of packet
- ready_encap_dfx  out  1  idle, able to accept a grant

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE.
  - ready_encap_dfx=1; data_encap_valid=0; data_encap_last=0; data_in_port_0=0.
  - Shift register, header register and flit index are cleared.
  - Reset takes effect mid-packet and discards the packet; no further flits are emitted.
- Two states: IDLE and SEND. All outputs are registered.
- IDLE:
  - If arbiter_gnt=1, capture data_dfx_send into the shift register and header_pkt_send into the header register.
  - idx <= 0; go to SEND.
  - ready_encap_dfx goes 0, data_encap_valid goes 1, and flit 0 is presented in the next cycle.
  - Latency: grant in cycle N, first flit valid in cycle N+1.
- Flit k payload = data[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH], LSB-first.
  - Bits beyond DATA_DFX_WIDTH are zero-padded.
  - Default: flit 18 carries 44 data bits plus 11 zero bits.
  - Header field is identical in every flit of a packet.
- SEND:
  - Accept = data_encap_valid & tx_ready.
  - On accept with idx<NUM_FLITS-1: shift right by PAYLOAD_WIDTH, idx++, present the next flit in the next cycle.
  - While valid & !tx_ready: data_in_port_0, data_encap_valid and data_encap_last hold stable.
  - data_encap_last=1 exactly while flit NUM_FLITS-1 is presented.
  - On accept of the last flit: valid=0 and last=0 next cycle; return to IDLE; ready_encap_dfx=1 next cycle.
- Back-to-back packets: there is a minimum of one cycle with ready_encap_dfx=1 between packets. A grant in the cycle the last flit is accepted is ignored.
- arbiter_gnt is ignored while in SEND; the captured data and header are unaffected.
- encap_abort:
  - In SEND, abort has priority over a simultaneous accept. Valid and last drop next cycle, state goes to IDLE, ready goes 1 next cycle, and the partial packet is not completed.
  - In IDLE, abort is ignored; grant is processed normally when both are high.
- data_in_port_0 holds its last value when valid=0 and carries no meaning; it is cleared only by reset.

Optional Feature:
- Macro: ENCAP_PKT_CNT_EN.
- Defined:
  - Adds output pkt_sent_cnt [15:0] and output pkt_abort_cnt [15:0].
  - pkt_sent_cnt increments on last-flit accept; pkt_abort_cnt increments on an abort taken in SEND.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Single packet, tx_ready=1: rst, then gnt for 1 cycle with data = 1034-bit pattern, 10'h2AA address, header=9'h155 -> 19 consecutive valid flits; flit k = {data[k*55+:55], 9'h155}; last=1 only on flit 18; flit 18 bits [63:53] = 0; ready=1 one cycle after flit 18.
- Backpressure: same packet, tx_ready toggles 1,0,0,1 repeating -> every flit held stable while tx_ready=0; no flit lost or duplicated; 19 accepts total.
- Abort: encap_abort=1 together with tx_ready=1 on flit 7 -> flit 7 not counted as accepted, valid=0 and ready=1 next cycle; a new grant with data all-ones/header 9'h1FF then yields flit 0 = {55'h7F_FFFF_FFFF_FFFF, 9'h1FF}.
- Grant during SEND: pulse arbiter_gnt with different data at flit 5 -> output stream unchanged from the original packet.
- Reset mid-packet: rst=1 at flit 10 -> next cycle valid=0, last=0, data_in_port_0=0, ready=1; no further flits.
- ENCAP_PKT_CNT_EN: 3 completed packets and 1 aborted -> pkt_sent_cnt=3, pkt_abort_cnt=1.

Source files
------------

// File: rtl/encap_packet_stream.sv
// Packet encapsulator: captures one DFX word plus header on grant and streams NUM_FLITS {payload, header} flits.
// Optional ENCAP_PKT_CNT_EN adds saturating sent/abort packet counters.
module encap_packet_stream #(
    parameter int DATA_DFX_WIDTH    = 1034,
    parameter int HEADER_WIDTH      = 9,
    parameter int AURORA_DATA_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_DFX_WIDTH-1:0]    data_dfx_send,
    input  logic [HEADER_WIDTH-1:0]      header_pkt_send,
    input  logic                         arbiter_gnt,
    input  logic                         encap_abort,
    input  logic                         tx_ready,
    output logic [AURORA_DATA_WIDTH-1:0] data_in_port_0,
    output logic                         data_encap_valid,
    output logic                         data_encap_last,
    output logic                         ready_encap_dfx
`ifdef ENCAP_PKT_CNT_EN
    ,
    output logic [15:0]                  pkt_sent_cnt,
    output logic [15:0]                  pkt_abort_cnt
`endif
);
    localparam int PAYLOAD_WIDTH = AURORA_DATA_WIDTH - HEADER_WIDTH;
    localparam int NUM_FLITS     = (DATA_DFX_WIDTH + PAYLOAD_WIDTH - 1) / PAYLOAD_WIDTH;
    localparam int IDX_WIDTH     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
    localparam int SHIFT_WIDTH   = NUM_FLITS * PAYLOAD_WIDTH;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_FLITS - 1);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t                   r_state, w_state_nxt;
    logic [SHIFT_WIDTH-1:0]   r_shift, w_shift_nxt;
    logic [HEADER_WIDTH-1:0]  r_hdr,   w_hdr_nxt;
    logic [IDX_WIDTH-1:0]     r_idx,   w_idx_nxt;
    logic [IDX_WIDTH-1:0]     w_idx_inc;
    logic                     r_valid, w_valid_nxt;
    logic                     r_last,  w_last_nxt;
    logic                     r_ready, w_ready_nxt;

    assign w_idx_inc = r_idx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_hdr_nxt   = r_hdr;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_ready_nxt = r_ready;
        unique case (r_state)
            S_IDLE: begin
                if (arbiter_gnt) begin
                    // Zero-extension into the wider shift register pads the final flit.
                    w_shift_nxt = SHIFT_WIDTH'(data_dfx_send);
                    w_hdr_nxt   = header_pkt_send;
                    w_idx_nxt   = '0;
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = (LAST_IDX == '0);
                    w_ready_nxt = 1'b0;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (encap_abort) begin
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_ready_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_valid && tx_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_ready_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_shift_nxt = r_shift >> PAYLOAD_WIDTH;
                        w_idx_nxt   = w_idx_inc;
                        w_last_nxt  = (w_idx_inc == LAST_IDX);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_hdr   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_hdr   <= w_hdr_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    assign data_in_port_0   = {r_shift[PAYLOAD_WIDTH-1:0], r_hdr};
    assign data_encap_valid = r_valid;
    assign data_encap_last  = r_last;
    assign ready_encap_dfx  = r_ready;

`ifdef ENCAP_PKT_CNT_EN
    logic        w_sent, w_abort_taken;
    logic [15:0] r_pkt_sent, r_pkt_abort;

    assign w_abort_taken = (r_state == S_SEND) && encap_abort;
    assign w_sent        = (r_state == S_SEND) && !encap_abort && r_valid && tx_ready
                           && (r_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_sent  <= '0;
            r_pkt_abort <= '0;
        end else begin
            if (w_sent && (r_pkt_sent != '1))
                r_pkt_sent <= r_pkt_sent + 1'b1;
            if (w_abort_taken && (r_pkt_abort != '1))
                r_pkt_abort <= r_pkt_abort + 1'b1;
        end
    end

    assign pkt_sent_cnt  = r_pkt_sent;
    assign pkt_abort_cnt = r_pkt_abort;
`endif
endmodule

// File: tb/tb_encap_packet_stream.sv
// Self-checking bench for encap_packet_stream: vector table plus directed multi-cycle sequences.
module tb_encap_packet_stream;
    localparam int DW   = 1034;
    localparam int HW   = 9;
    localparam int AW   = 64;
    localparam int PW   = AW - HW;
    localparam int NF   = 19;
    localparam int PADW = NF * PW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_dfx_send = '0;
    logic [HW-1:0] header_pkt_send = '0;
    logic          arbiter_gnt = 1'b0;
    logic          encap_abort = 1'b0;
    logic          tx_ready = 1'b0;
    logic [AW-1:0] data_in_port_0;
    logic          data_encap_valid;
    logic          data_encap_last;
    logic          ready_encap_dfx;
`ifdef ENCAP_PKT_CNT_EN
    logic [15:0]   pkt_sent_cnt;
    logic [15:0]   pkt_abort_cnt;
`endif

    encap_packet_stream #(
        .DATA_DFX_WIDTH(DW),
        .HEADER_WIDTH(HW),
        .AURORA_DATA_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_dfx_send(data_dfx_send),
        .header_pkt_send(header_pkt_send),
        .arbiter_gnt(arbiter_gnt),
        .encap_abort(encap_abort),
        .tx_ready(tx_ready),
        .data_in_port_0(data_in_port_0),
        .data_encap_valid(data_encap_valid),
        .data_encap_last(data_encap_last),
        .ready_encap_dfx(ready_encap_dfx)
`ifdef ENCAP_PKT_CNT_EN
        ,
        .pkt_sent_cnt(pkt_sent_cnt),
        .pkt_abort_cnt(pkt_abort_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] pat;
    logic [DW-1:0] ones;

    typedef struct {
        logic gnt;
        logic abort;
        logic txr;
        logic ev;
        logic el;
        logic er;
        int   eidx;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [AW-1:0] flit(input logic [DW-1:0] d, input logic [HW-1:0] h, input int k);
        logic [PADW-1:0] p;
        p = PADW'(d);
        return {p[k*PW +: PW], h};
    endfunction

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_out(input string name, input logic ev, input logic el, input logic er,
                           input logic [AW-1:0] edat);
        chk({name, ".valid"}, AW'(data_encap_valid), AW'(ev));
        chk({name, ".last"},  AW'(data_encap_last),  AW'(el));
        chk({name, ".ready"}, AW'(ready_encap_dfx),  AW'(er));
        chk({name, ".data"},  data_in_port_0,        edat);
    endtask

    task automatic do_reset();
        rst = 1'b1; arbiter_gnt = 1'b0; encap_abort = 1'b0; tx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_out("reset", 1'b0, 1'b0, 1'b1, '0);
        rst = 1'b0;
    endtask

    // Full packet with tx_ready held high; optional foreign grant at flit 5, grant also raised on the last accept.
    task automatic run_full(input logic [DW-1:0] d, input logic [HW-1:0] h, input bit mid_gnt, input string tag);
        data_dfx_send = d; header_pkt_send = h; arbiter_gnt = 1'b1; tx_ready = 1'b1;
        for (int k = 0; k < NF; k++) begin
            @(negedge clk);
            chk_out($sformatf("%s.flit%0d", tag, k), 1'b1, k == NF-1, 1'b0, flit(d, h, k));
            if (k == NF-1) chk({tag, ".pad"}, AW'(data_in_port_0[63:53]), '0);
            arbiter_gnt     = (mid_gnt && k == 5) || (k == NF-1);
            data_dfx_send   = (k == 5) ? ~d : d;
            header_pkt_send = (k == 5) ? ~h : h;
        end
        @(negedge clk);
        arbiter_gnt = 1'b0;
        chk_out({tag, ".post"}, 1'b0, 1'b0, 1'b1, flit(d, h, NF-1));
        @(negedge clk);
        chk_out({tag, ".idle"}, 1'b0, 1'b0, 1'b1, flit(d, h, NF-1));
    endtask

    initial begin
        int acc;
        int ex;
        for (int j = 0; j < 32; j++) pat[j*32 +: 32] = 32'h1234_5600 + j * 32'h0101_0101;
        pat[DW-1:1024] = 10'h2AA;
        ones = '1;

        // {gnt, abort, txr, exp_valid, exp_last, exp_ready, exp_flit}; checked at negedge, then inputs applied
        tbl[0]  = '{1, 0, 0, 0, 0, 1, -1};
        tbl[1]  = '{0, 0, 0, 1, 0, 0,  0};
        tbl[2]  = '{0, 0, 1, 1, 0, 0,  0};
        tbl[3]  = '{1, 0, 1, 1, 0, 0,  1};
        tbl[4]  = '{0, 0, 0, 1, 0, 0,  2};
        tbl[5]  = '{0, 1, 0, 1, 0, 0,  2};
        tbl[6]  = '{1, 1, 0, 0, 0, 1,  2};
        tbl[7]  = '{0, 0, 1, 1, 0, 0,  0};
        tbl[8]  = '{0, 1, 1, 1, 0, 0,  1};
        tbl[9]  = '{0, 0, 0, 0, 0, 1,  1};
        tbl[10] = '{0, 0, 0, 0, 0, 1,  1};

        // Table-driven short sequences: hold, grant ignored in SEND, abort, abort+grant in IDLE
        do_reset();
        data_dfx_send = pat; header_pkt_send = 9'h155;
        for (int i = 0; i < 11; i++) begin
            chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].el, tbl[i].er,
                    (tbl[i].eidx < 0) ? '0 : flit(pat, 9'h155, tbl[i].eidx));
            arbiter_gnt = tbl[i].gnt;
            encap_abort = tbl[i].abort;
            tx_ready    = tbl[i].txr;
            @(negedge clk);
        end
        arbiter_gnt = 1'b0; encap_abort = 1'b0; tx_ready = 1'b0;

        // Single packet, no backpressure
        do_reset();
        run_full(pat, 9'h155, 1'b0, "full");

        // Grant during SEND with different data
        run_full(pat, 9'h155, 1'b1, "midgnt");

        // Backpressure: tx_ready pattern 1,0,0,1
        data_dfx_send = pat; header_pkt_send = 9'h0A5; arbiter_gnt = 1'b1; tx_ready = 1'b0;
        @(negedge clk);
        arbiter_gnt = 1'b0;
        acc = 0; ex = 0;
        for (int c = 0; c < 200 && acc < NF; c++) begin
            chk_out($sformatf("bp.c%0d", c), 1'b1, ex == NF-1, 1'b0, flit(pat, 9'h0A5, ex));
            tx_ready = (c % 4 == 0) || (c % 4 == 3);
            if (tx_ready) begin acc++; ex++; end
            @(negedge clk);
        end
        tx_ready = 1'b0;
        chk("bp.accepts", AW'(acc), AW'(NF));
        chk_out("bp.done", 1'b0, 1'b0, 1'b1, flit(pat, 9'h0A5, NF-1));

        // Abort on flit 7 with tx_ready high, then new all-ones packet
        data_dfx_send = pat; header_pkt_send = 9'h155; arbiter_gnt = 1'b1; tx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            arbiter_gnt = 1'b0;
            chk_out($sformatf("ab.flit%0d", k), 1'b1, 1'b0, 1'b0, flit(pat, 9'h155, k));
            encap_abort = (k == 7);
        end
        @(negedge clk);
        encap_abort = 1'b0;
        chk_out("ab.after", 1'b0, 1'b0, 1'b1, flit(pat, 9'h155, 7));
        data_dfx_send = ones; header_pkt_send = 9'h1FF; arbiter_gnt = 1'b1; tx_ready = 1'b0;
        @(negedge clk);
        arbiter_gnt = 1'b0;
        chk_out("ab.new0", 1'b1, 1'b0, 1'b0, {55'h7F_FFFF_FFFF_FFFF, 9'h1FF});
        tx_ready = 1'b1;
        @(negedge clk);
        chk_out("ab.new1", 1'b1, 1'b0, 1'b0, {55'h7F_FFFF_FFFF_FFFF, 9'h1FF});
        tx_ready = 1'b0; encap_abort = 1'b1;
        @(negedge clk);
        encap_abort = 1'b0;
        chk_out("ab.clear", 1'b0, 1'b0, 1'b1, {55'h7F_FFFF_FFFF_FFFF, 9'h1FF});

        // Reset mid-packet at flit 10
        data_dfx_send = pat; header_pkt_send = 9'h155; arbiter_gnt = 1'b1; tx_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            arbiter_gnt = 1'b0;
            chk_out($sformatf("rst.flit%0d", k), 1'b1, 1'b0, 1'b0, flit(pat, 9'h155, k));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_out("rst.after", 1'b0, 1'b0, 1'b1, '0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("rst.quiet%0d", c), AW'(data_encap_valid), '0);
        end
        tx_ready = 1'b0;

`ifdef ENCAP_PKT_CNT_EN
        do_reset();
        chk("cnt.sent0",  AW'(pkt_sent_cnt),  '0);
        chk("cnt.abort0", AW'(pkt_abort_cnt), '0);
        for (int p = 0; p < 3; p++) run_full(pat, 9'h033, 1'b0, $sformatf("cnt.p%0d", p));
        data_dfx_send = pat; arbiter_gnt = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        arbiter_gnt = 1'b0;
        @(negedge clk);
        encap_abort = 1'b1;
        @(negedge clk);
        encap_abort = 1'b0; tx_ready = 1'b0;
        @(negedge clk);
        chk("cnt.sent",  AW'(pkt_sent_cnt),  AW'(3));
        chk("cnt.abort", AW'(pkt_abort_cnt), AW'(1));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
